// File: rtl/fx_kp_pad.sv
// PC-FX K-port joypad endpoint: serialises the pad word to the KPC and
// deserialises the 32-bit word the system shifts out to the pad.
module fx_kp_pad #(
    parameter logic [3:0] PAD_ID = 4'hF
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic        CONNECTED,
    input  logic [11:0] BTN,
    input  logic        MODE1,
    input  logic        MODE2,
    input  logic        KP_LATCH,
    input  logic        KP_CLK,
    input  logic        KP_RW,
    input  logic        KP_DOUT,
    output logic        KP_DIN,
    output logic [31:0] RX_DATA,
    output logic        RX_STB
);

    logic        latch_s;
    logic        latch_h;
    logic        clk_s;
    logic        clk_h;
    logic        dout_s;
    logic        dl;
    logic [4:0]  cnt;
    logic [31:0] sr;
    logic [31:0] pad_word;
    logic [31:0] sr_shift;
    logic        latch_rise;
    logic        clk_rise;
    logic        clk_fall;

    always_comb begin
        pad_word = '0;
        if (CONNECTED) begin
            pad_word = {PAD_ID, 13'd0, MODE2, 1'b0, MODE1, BTN};
        end
    end

    // A latch edge masks any clock edge seen on the same CE cycle
    assign latch_rise = latch_s & ~latch_h;
    assign clk_rise   = clk_s & ~clk_h & ~latch_rise;
    assign clk_fall   = ~clk_s & clk_h & ~latch_rise;
    assign sr_shift   = {dl, sr[31:1]};

    assign KP_DIN = KP_RW | ~sr[0];

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            latch_s <= 1'b0;
            latch_h <= 1'b0;
            clk_s   <= 1'b0;
            clk_h   <= 1'b0;
            dout_s  <= 1'b0;
            dl      <= 1'b0;
            cnt     <= '0;
            sr      <= '0;
            RX_DATA <= '0;
            RX_STB  <= 1'b0;
        end else if (CE) begin
            latch_s <= KP_LATCH;
            latch_h <= latch_s;
            clk_s   <= KP_CLK;
            clk_h   <= clk_s;
            dout_s  <= KP_DOUT;
            RX_STB  <= 1'b0;
            if (latch_rise) begin
                sr  <= pad_word;
                cnt <= '0;
            end else if (clk_rise) begin
                sr  <= sr_shift;
                cnt <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    RX_DATA <= sr_shift;
                    RX_STB  <= 1'b1;
                end
            end
            if (clk_fall) begin
                dl <= ~dout_s;
            end
        end
    end

endmodule

// File: tb/tb_fx_kp_pad.sv
// Scoreboard bench for fx_kp_pad: wire bits and received words are queued
// when driven and popped when the pad produces them.
module tb_fx_kp_pad;

    logic        CLK = 1'b0;
    logic        RESn = 1'b0;
    logic        CE = 1'b1;
    logic        CONNECTED = 1'b0;
    logic [11:0] BTN = '0;
    logic        MODE1 = 1'b0;
    logic        MODE2 = 1'b0;
    logic        KP_LATCH = 1'b0;
    logic        KP_CLK = 1'b1;
    logic        KP_RW = 1'b0;
    logic        KP_DOUT = 1'b1;
    logic        KP_DIN;
    logic [31:0] RX_DATA;
    logic        RX_STB;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;
    logic [31:0] rx_q[$];
    logic        bit_q[$];

    fx_kp_pad #(.PAD_ID(4'hF)) dut (
        .CLK(CLK), .RESn(RESn), .CE(CE), .CONNECTED(CONNECTED),
        .BTN(BTN), .MODE1(MODE1), .MODE2(MODE2),
        .KP_LATCH(KP_LATCH), .KP_CLK(KP_CLK), .KP_RW(KP_RW),
        .KP_DOUT(KP_DOUT), .KP_DIN(KP_DIN),
        .RX_DATA(RX_DATA), .RX_STB(RX_STB)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    always @(negedge CLK) begin
        if (RESn && RX_STB) begin
            logic [31:0] e;
            stb_cnt++;
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL rx_stb unexpected RX_DATA=%h", RX_DATA);
            end else begin
                e = rx_q.pop_front();
                if (RX_DATA !== e) begin
                    errors++;
                    $display("FAIL rx_word got %h want %h", RX_DATA, e);
                end
            end
        end
    end

    function automatic logic [31:0] pad_model(input logic c,
                                              input logic [11:0] b,
                                              input logic m1,
                                              input logic m2);
        logic [31:0] w;
        w = 32'd0;
        if (c) begin
            w[11:0]  = b;
            w[12]    = m1;
            w[14]    = m2;
            w[31:28] = 4'hF;
        end
        return w;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic kp_latch();
        KP_LATCH = 1'b1;
        tick(4);
        KP_LATCH = 1'b0;
        tick(4);
    endtask

    task automatic kp_clock(input logic dout_wire);
        KP_DOUT = dout_wire;
        KP_CLK = 1'b0;
        tick(4);
        KP_CLK = 1'b1;
        tick(4);
    endtask

    // change_at: bit index where pad inputs are disturbed (-1 = never)
    // ce_at: bit index where a CE=0 window with pin pulses is inserted
    task automatic run_input(input string name, input logic [31:0] want,
                             input int change_at, input int ce_at);
        logic [31:0] w;
        logic [31:0] got;
        logic        b;
        int          s0;
        KP_RW = 1'b0;
        KP_DOUT = 1'b1;
        w = pad_model(CONNECTED, BTN, MODE1, MODE2);
        for (int i = 0; i < 32; i++) bit_q.push_back(~w[i]);
        rx_q.push_back(32'd0);
        s0 = stb_cnt;
        kp_latch();
        got = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == change_at) begin
                BTN = ~BTN;
                MODE1 = ~MODE1;
                MODE2 = ~MODE2;
                CONNECTED = ~CONNECTED;
                tick(2);
            end
            if (i == ce_at) begin
                CE = 1'b0;
                tick(2);
                KP_CLK = 1'b0;
                KP_LATCH = 1'b1;
                tick(4);
                KP_CLK = 1'b1;
                KP_LATCH = 1'b0;
                tick(4);
                CE = 1'b1;
                tick(4);
            end
            @(negedge CLK);
            b = bit_q.pop_front();
            checks++;
            if (KP_DIN !== b) begin
                errors++;
                $display("FAIL %s bit%0d got %b want %b", name, i, KP_DIN, b);
            end
            got[i] = ~KP_DIN;
            kp_clock(1'b1);
        end
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s word got %h want %h", name, got, want);
        end
        checks++;
        if (stb_cnt !== s0 + 1) begin
            errors++;
            $display("FAIL %s stb_count got %0d want %0d", name, stb_cnt - s0, 1);
        end
    endtask

    task automatic run_output(input string name, input logic [31:0] word);
        int s0;
        KP_RW = 1'b1;
        rx_q.push_back(word);
        s0 = stb_cnt;
        kp_latch();
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            checks++;
            if (KP_DIN !== 1'b1) begin
                errors++;
                $display("FAIL %s din_idle bit%0d got %b want 1", name, i, KP_DIN);
            end
            if (i == 31) begin
                checks++;
                if (stb_cnt !== s0) begin
                    errors++;
                    $display("FAIL %s early_stb got %0d want 0", name, stb_cnt - s0);
                end
            end
            kp_clock(~word[i]);
        end
        checks++;
        if (stb_cnt !== s0 + 1) begin
            errors++;
            $display("FAIL %s stb_count got %0d want 1", name, stb_cnt - s0);
        end
        checks++;
        if (RX_DATA !== word) begin
            errors++;
            $display("FAIL %s rx_data got %h want %h", name, RX_DATA, word);
        end
    endtask

    task automatic test_reset();
        RESn = 1'b0;
        KP_RW = 1'($urandom);
        KP_DOUT = 1'($urandom);
        KP_LATCH = 1'($urandom);
        BTN = 12'($urandom);
        CONNECTED = 1'($urandom);
        tick(5);
        checks++;
        if (KP_DIN !== 1'b1 || RX_DATA !== 32'd0 || RX_STB !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got din=%b rx=%h stb=%b want 1/0/0",
                     KP_DIN, RX_DATA, RX_STB);
        end
        KP_LATCH = 1'b0;
        KP_CLK = 1'b1;
        KP_DOUT = 1'b1;
        RESn = 1'b1;
        tick(10);
        checks++;
        if (KP_DIN !== 1'b1 || RX_DATA !== 32'd0 || stb_cnt !== 0) begin
            errors++;
            $display("FAIL reset_release got din=%b rx=%h stb=%0d want 1/0/0",
                     KP_DIN, RX_DATA, stb_cnt);
        end
    endtask

    task automatic test_input_frame();
        CONNECTED = 1'b1;
        BTN = 12'hA5C;
        MODE1 = 1'b1;
        MODE2 = 1'b0;
        run_input("input_frame", 32'hF000_1A5C, -1, -1);
        BTN = 12'h3C1;
        MODE1 = 1'b0;
        MODE2 = 1'b1;
        run_input("input_mode2", 32'hF000_43C1, -1, -1);
    endtask

    task automatic test_disconnected();
        CONNECTED = 1'b0;
        BTN = 12'hA5C;
        MODE1 = 1'b1;
        MODE2 = 1'b0;
        run_input("disconnected", 32'h0000_0000, -1, -1);
    endtask

    task automatic test_output_frame();
        run_output("output_frame", 32'h50FA_AF05);
    endtask

    task automatic test_mid_btn();
        CONNECTED = 1'b1;
        BTN = 12'h9E7;
        MODE1 = 1'b0;
        MODE2 = 1'b1;
        run_input("mid_btn", 32'hF000_49E7, 10, -1);
        CONNECTED = 1'b1;
    endtask

    task automatic test_ce_gap();
        CONNECTED = 1'b1;
        BTN = 12'h5A3;
        MODE1 = 1'b1;
        MODE2 = 1'b1;
        run_input("ce_gap", 32'hF000_55A3, -1, 5);
    endtask

    task automatic test_relatch();
        int s0;
        KP_RW = 1'b1;
        s0 = stb_cnt;
        kp_latch();
        for (int i = 0; i < 10; i++) kp_clock(1'($urandom));
        checks++;
        if (stb_cnt !== s0) begin
            errors++;
            $display("FAIL relatch_partial stb got %0d want 0", stb_cnt - s0);
        end
        run_output("relatch", 32'h1357_9BDF);
    endtask

    task automatic test_async_reset();
        int s0;
        KP_RW = 1'b1;
        s0 = stb_cnt;
        kp_latch();
        for (int i = 0; i < 16; i++) kp_clock(1'($urandom));
        #2;
        RESn = 1'b0;
        #1;
        checks++;
        if (RX_DATA !== 32'd0 || KP_DIN !== 1'b1 || RX_STB !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got rx=%h din=%b stb=%b want 0/1/0",
                     RX_DATA, KP_DIN, RX_STB);
        end
        tick(3);
        RESn = 1'b1;
        tick(6);
        checks++;
        if (RX_DATA !== 32'd0 || stb_cnt !== s0) begin
            errors++;
            $display("FAIL async_release got rx=%h stb=%0d want 0/0",
                     RX_DATA, stb_cnt - s0);
        end
        run_output("after_reset", 32'hCDEF_1234);
    endtask

    initial begin
        test_reset();
        test_input_frame();
        test_disconnected();
        test_output_frame();
        test_mid_btn();
        test_ce_gap();
        test_relatch();
        test_async_reset();
        tick(10);
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL rx_pending got %0d want 0", rx_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fx_kp_pad.md
Name: fx_kp_pad

Overview:
- Controller-side endpoint of the PC-FX K-port.
- Emulates one standard PC-FX joypad attached to the KP_* pins that fx_ga_kpc drives; receives the same KP_LATCH/KP_CLK/KP_RW strobes and returns KP_DIN.
- Serialises a 32-bit pad word (system input direction) and deserialises the 32-bit word the system shifts out (output direction).
- Sits between fx_ga_kpc and the MiSTer HPS joystick bits.

Parameters:
- PAD_ID, 4'hF, device ID placed in word bits 31:28 (F = standard pad).

Ports:
- CLK  in  1  system clock.
- RESn  in  1  reset.
- CE  in  1  clock enable; all logic advances only on CE=1 cycles.
- CONNECTED  in  1  1 = pad present; 0 = port reads as empty.
- BTN  in  12  bits 0-7: I, II, III, IV, V, VI, Select, Run; bits 8-11: Up, Right, Down, Left. Active-high.
- MODE1  in  1  mode-1 switch, active-high.
- MODE2  in  1  mode-2 switch, active-high.
- KP_LATCH  in  1  latch strobe from the KPC.
- KP_CLK  in  1  shift clock from the KPC.
- KP_RW  in  1  1 = system→pad (output), 0 = pad→system (input).
- KP_DOUT  in  1  serial data from the KPC; active-low on wire.
- KP_DIN  out  1  serial data to the KPC; active-low on wire.
- RX_DATA  out  32  last complete word received from the system.
- RX_STB  out  1  one-CE-cycle pulse when RX_DATA updates.

Interface: one clock (CLK); reset RESn is asynchronous and active-low.

Behaviour:
- Reset values: KP_DIN=1, RX_DATA=0, RX_STB=0, shift register=0, bit counter=0, latched DOUT bit=0, edge-detect history=0.
- Input sampling: KP_LATCH, KP_CLK and KP_DOUT are registered once per CE cycle. Edges are detected against the previous CE sample, so an edge is seen one CE cycle after the pin changes.
- Pad word (active-high logical value W):
  - W[11:0] = BTN
  - W[12] = MODE1
  - W[13] = 0
  - W[14] = MODE2
  - W[27:15] = 0
  - W[31:28] = PAD_ID
  - If CONNECTED=0, W=0.
- Latch rising edge:
  - SR <= W (BTN/MODE snapshotted on this CE cycle).
  - Bit counter <= 0.
  - Takes priority over a coincident KP_CLK edge, which is then ignored.
- KP_CLK falling edge: DL <= ~KP_DOUT_sampled (captures the system bit, converted to logical level).
- KP_CLK rising edge:
  - SR <= {DL, SR[31:1]}, LSB first.
  - Counter increments.
  - On the 32nd rising edge since latch: RX_DATA <= {DL, SR[31:1]} (the shifted value), RX_STB=1 for that CE cycle, counter wraps to 0.
  - Clock edges beyond 32 keep shifting and start a new 32-count.
- KP_DIN = KP_RW | ~SR[0], combinational from the registered SR and the raw KP_RW pin. While KP_RW=1 the line idles high.
- Input direction: the system reads bit n after n rising edges and sees ~W[n] on the wire.
- Output direction: the word shifted in ends up in SR and RX_DATA as the logical value the system wrote.
- Changes to BTN, MODE or CONNECTED mid-frame do not affect the frame in progress; they take effect at the next latch.
- Async reset mid-frame: all state clears immediately. The next latch restarts cleanly.
- CE=0: nothing advances. Pin pulses shorter than one CE period are not guaranteed to be seen.

Test Plan:
- Reset: hold RESn=0 with random pins → KP_DIN=1, RX_DATA=0, RX_STB=0. Release → outputs unchanged until the first latch.
- Input frame: CONNECTED=1, BTN=12'hA5C, MODE1=1, MODE2=0, KP_RW=0; latch then 32 clocks → system assembles 32'hF000_1A5C, i.e. wire bits = inverted.
- Disconnected: CONNECTED=0, same sequence → assembled word 32'h0000_0000 (KP_DIN held 1 every bit).
- Output frame: KP_RW=1, system shifts 32'h50FAAF05 over KP_DOUT (active-low) → RX_DATA=32'h50FAAF05, exactly one RX_STB pulse on the 32nd rising edge, KP_DIN=1 throughout.
- Mid-frame events:
  - Change BTN after 10 clocks → remaining bits still from the original snapshot.
  - Re-latch after 10 clocks → counter restarts, with no RX_STB until 32 further clocks.
- Async reset after 16 clocks of an output frame → RX_DATA stays 0, no RX_STB. A following full frame of 32'hCDEF1234 → RX_DATA=32'hCDEF1234.
